// File: rtl/psram_resp_model_if.sv
`default_nettype none
// ============================================================================
// Module  : psram_resp_model_if
// Brief   : SPI/QPI PSRAM link bundle between the axi4_psram controller
//           (master) and the psram_resp_model device responder (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface psram_resp_model_if;
    logic       psram_sck_i;
    logic       psram_ce_i;
    logic [3:0] psram_io_i;
    logic [3:0] psram_io_o;
    logic [3:0] psram_io_en_o;

    modport master (
        output psram_sck_i, psram_ce_i, psram_io_i,
        input  psram_io_o, psram_io_en_o
    );

    modport slave (
        input  psram_sck_i, psram_ce_i, psram_io_i,
        output psram_io_o, psram_io_en_o
    );
endinterface
`default_nettype wire

// File: rtl/psram_resp_model.sv
`default_nettype none
// ============================================================================
// Module  : psram_resp_model
// Brief   : Device-side PSRAM responder. Oversamples the SPI/QPI link in the
//           clk_i domain, decodes command/address/wait/data phases and serves
//           reads and writes from an internal byte array.
//           Optional feature macro: PSRAM_RESP_QPI_EN (0x35/0xF5 QPI mode).
// Revision: 1.0 - initial release
// ============================================================================
module psram_resp_model #(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 24,
    parameter int QRD_WAIT   = 6,
    parameter int FRD_WAIT   = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    psram_resp_model_if.slave  link,
    output logic               busy_o,
    output logic               err_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int SH_W  = (IDX_W > 8) ? IDX_W : 8;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] QRD_W     = CNT_W'(QRD_WAIT);
    localparam logic [CNT_W-1:0] FRD_W     = CNT_W'(FRD_WAIT);
    localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] ADDR_NIBS = CNT_W'(ADDR_WIDTH / 4 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_WAIT   = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    logic             sck_s1_q, sck_s2_q, sck_prev_q, ce_s1_q, ce_s2_q;
    logic [3:0]       io_s1_q, io_s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, wait_q, wait_d;
    logic [SH_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             rd_q, rd_d, quad_q, quad_d, err_q, err_d;
    logic [3:0]       io_o_q, io_o_d, io_en_q, io_en_d;
    logic [7:0]       mem_q [MEM_DEPTH];

    logic             w_rise, w_fall, w_wide, w_cmd_done, w_mem_we, w_unused;
    logic [SH_W-1:0]  w_shift_next;
    logic [7:0]       w_cmd_byte, w_rd_byte;
    logic [CNT_W-1:0] w_cmd_last, w_addr_last, w_data_last;
    logic             dec_ok, dec_rd, dec_quad, dec_addr;
    logic [CNT_W-1:0] dec_wait;
    logic             qpi_q;

    // two-flop synchronizers for the link inputs plus previous-SCK for edges
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            ce_s1_q    <= 1'b1;
            ce_s2_q    <= 1'b1;
            io_s1_q    <= 4'h0;
            io_s2_q    <= 4'h0;
        end else begin
            sck_s1_q   <= link.psram_sck_i;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            ce_s1_q    <= link.psram_ce_i;
            ce_s2_q    <= ce_s1_q;
            io_s1_q    <= link.psram_io_i;
            io_s2_q    <= io_s1_q;
        end
    end

    assign w_rise       = sck_s2_q & ~sck_prev_q;
    assign w_fall       = ~sck_s2_q & sck_prev_q;
    // the command phase follows the link mode; later phases follow the opcode
    assign w_wide       = (state_q == S_CMD) ? qpi_q : quad_q;
    assign w_shift_next = w_wide ? {shift_q[SH_W-5:0], io_s2_q}
                                 : {shift_q[SH_W-2:0], io_s2_q[0]};
    assign w_cmd_byte   = w_shift_next[7:0];
    assign w_cmd_last   = qpi_q  ? CNT_W'(1) : CNT_W'(7);
    assign w_addr_last  = quad_q ? ADDR_NIBS : ADDR_BITS;
    assign w_data_last  = quad_q ? CNT_W'(1) : CNT_W'(7);
    assign w_rd_byte    = mem_q[addr_q];
    assign w_unused     = shift_q[SH_W-1];

`ifdef PSRAM_RESP_QPI_EN
    logic qpi_d, pend_q, pend_d;

    // QPI mode flag and the 0x66 -> 0x99 reset pair, updated per opcode
    always_comb begin
        qpi_d  = qpi_q;
        pend_d = pend_q;
        if (w_cmd_done) begin
            pend_d = (w_cmd_byte == 8'h66);
            case (w_cmd_byte)
                8'h35:   qpi_d = 1'b1;
                8'hF5:   qpi_d = 1'b0;
                8'h99:   if (pend_q) qpi_d = 1'b0;
                default: ;
            endcase
        end
    end

    // QPI mode registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            qpi_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            qpi_q  <= qpi_d;
            pend_q <= pend_d;
        end
    end
`else
    assign qpi_q = 1'b0;
`endif

    // opcode decode; in QPI mode the SPI read opcodes take quad-read timing
    always_comb begin
        dec_ok   = 1'b1;
        dec_rd   = 1'b0;
        dec_quad = qpi_q;
        dec_addr = 1'b1;
        dec_wait = '0;
        case (w_cmd_byte)
            8'h03: begin dec_rd = 1'b1; dec_wait = qpi_q ? QRD_W : '0;    end
            8'h0B: begin dec_rd = 1'b1; dec_wait = qpi_q ? QRD_W : FRD_W; end
            8'hEB: begin dec_rd = 1'b1; dec_quad = 1'b1; dec_wait = QRD_W; end
            8'h02: ;
            8'h38: dec_quad = 1'b1;
            8'h66, 8'h99: dec_addr = 1'b0;
`ifdef PSRAM_RESP_QPI_EN
            8'h35, 8'hF5: dec_addr = 1'b0;
`endif
            default: begin dec_ok = 1'b0; dec_addr = 1'b0; end
        endcase
    end

    // link FSM: phase sequencing, shifting, data drive and byte writes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        quad_d     = quad_q;
        wait_d     = wait_q;
        io_o_d     = io_o_q;
        io_en_d    = io_en_q;
        err_d      = 1'b0;
        w_mem_we   = 1'b0;
        w_cmd_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                io_o_d  = 4'h0;
                io_en_d = 4'h0;
                if (!ce_s2_q) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                end
            end
            S_CMD: if (w_rise) begin
                shift_d = w_shift_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == w_cmd_last) begin
                    w_cmd_done = 1'b1;
                    cnt_d      = '0;
                    rd_d       = dec_rd;
                    quad_d     = dec_quad;
                    wait_d     = dec_wait;
                    if (!dec_ok) begin
                        err_d   = 1'b1;
                        state_d = S_IGNORE;
                    end else begin
                        state_d = dec_addr ? S_ADDR : S_IGNORE;
                    end
                end
            end
            S_ADDR: if (w_rise) begin
                shift_d = w_shift_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == w_addr_last) begin
                    addr_d = w_shift_next[IDX_W-1:0];
                    cnt_d  = '0;
                    if (wait_q != '0) state_d = S_WAIT;
                    else              state_d = rd_q ? S_RDATA : S_WDATA;
                end
            end
            S_WAIT: if (w_rise) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == wait_q - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: if (w_fall) begin
                if (quad_q) begin
                    io_o_d  = cnt_q[0] ? w_rd_byte[3:0] : w_rd_byte[7:4];
                    io_en_d = 4'hF;
                end else begin
                    io_o_d  = {2'b00, w_rd_byte[3'd7 - cnt_q[2:0]], 1'b0};
                    io_en_d = 4'b0010;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == w_data_last) begin
                    cnt_d  = '0;
                    addr_d = addr_q + IDX_W'(1);
                end
            end
            S_WDATA: if (w_rise) begin
                shift_d = w_shift_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == w_data_last) begin
                    w_mem_we = 1'b1;
                    cnt_d    = '0;
                    addr_d   = addr_q + IDX_W'(1);
                end
            end
            S_IGNORE: io_en_d = 4'h0;
            default:  state_d = S_IDLE;
        endcase
        // CE high aborts everything; an unfinished write byte never reaches memory
        if (ce_s2_q) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            io_o_d     = 4'h0;
            io_en_d    = 4'h0;
            err_d      = 1'b0;
            w_mem_we   = 1'b0;
            w_cmd_done = 1'b0;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            quad_q  <= 1'b0;
            wait_q  <= '0;
            io_o_q  <= 4'h0;
            io_en_q <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            quad_q  <= quad_d;
            wait_q  <= wait_d;
            io_o_q  <= io_o_d;
            io_en_q <= io_en_d;
            err_q   <= err_d;
        end
    end

    // backing store: complete bytes only, intentionally not cleared by reset
    always_ff @(posedge clk_i) begin
        if (w_mem_we) mem_q[addr_q] <= w_shift_next[7:0];
    end

    assign link.psram_io_o    = io_o_q;
    assign link.psram_io_en_o = io_en_q;
    assign busy_o             = (state_q != S_IDLE);
    assign err_o              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_resp_model.sv
`default_nettype none
// ============================================================================
// Module  : tb_psram_resp_model
// Brief   : Self-checking bench for psram_resp_model. Acts as the link
//           controller and compares read data against a byte-array model.
//           Honours PSRAM_RESP_QPI_EN for the QPI scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_psram_resp_model;
    localparam int DEPTH = 1024;
    localparam int QRD   = 6;
    localparam int FRD   = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, err;
    int   total = 0;
    int   bad = 0;
    int   err_cycles = 0;
    bit   m_qpi = 1'b0;
    logic [7:0] ref_mem [0:DEPTH-1];
    logic [7:0] wbuf [0:15];

    psram_resp_model_if lnk ();

    psram_resp_model #(
        .MEM_DEPTH(DEPTH), .ADDR_WIDTH(24), .QRD_WAIT(QRD), .FRD_WAIT(FRD)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .link   (lnk.slave),
        .busy_o (busy),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    // count clk cycles with err_o high
    always @(negedge clk) if (err === 1'b1) err_cycles++;

    // one SCK period: drive on the fall, sample DUT just before the rise
    task automatic xfer(input logic [3:0] drv, output logic [3:0] s_io, output logic [3:0] s_en);
        lnk.psram_io_i = drv;
        #40;
        s_io = lnk.psram_io_o;
        s_en = lnk.psram_io_en_o;
        #10 lnk.psram_sck_i = 1'b1;
        #50 lnk.psram_sck_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int nbits, input bit wide);
        logic [3:0] a, b;
        if (wide) begin
            for (int i = nbits / 4 - 1; i >= 0; i--) xfer(v[i*4 +: 4], a, b);
        end else begin
            for (int i = nbits - 1; i >= 0; i--) xfer({3'b000, v[i]}, a, b);
        end
    endtask

    task automatic begin_frame();
        lnk.psram_ce_i = 1'b0;
        #40;
    endtask

    task automatic end_frame();
        lnk.psram_io_i  = 4'h0;
        lnk.psram_ce_i  = 1'b1;
        #60;
    endtask

    task automatic run_cmd(input logic [7:0] op);
        begin_frame();
        send(32'(op), 8, m_qpi);
        end_frame();
    endtask

    // write n bytes from wbuf; phase widths follow the opcode rules
    task automatic run_write(input logic [7:0] op, input int addr, input int n);
        bit qd;
        qd = (op == 8'h38) || m_qpi;
        begin_frame();
        send(32'(op), 8, m_qpi);
        send(32'(addr), 24, qd);
        for (int k = 0; k < n; k++) begin
            send(32'(wbuf[k]), 8, qd);
            ref_mem[(addr + k) % DEPTH] = wbuf[k];
        end
        end_frame();
    endtask

    // read n bytes and compare each against the model
    task automatic run_read(input logic [7:0] op, input int addr, input int n, input string nm);
        logic [3:0] s_io, s_en, en_exp;
        logic [7:0] got;
        bit qd, en_ok;
        int nwait;
        qd    = (op == 8'hEB) || m_qpi;
        nwait = (op == 8'hEB || m_qpi) ? QRD : (op == 8'h0B) ? FRD : 0;
        begin_frame();
        send(32'(op), 8, m_qpi);
        send(32'(addr), 24, qd);
        en_ok = 1'b1;
        for (int w = 0; w < nwait; w++) begin
            xfer(4'h0, s_io, s_en);
            if (s_en !== 4'h0) en_ok = 1'b0;
        end
        total++;
        if (!en_ok) begin
            bad++;
            $display("FAIL %s wait_io_en: got nonzero, need 0", nm);
        end
        en_exp = qd ? 4'hF : 4'h2;
        for (int k = 0; k < n; k++) begin
            got   = 8'h00;
            en_ok = 1'b1;
            if (qd) begin
                for (int h = 0; h < 2; h++) begin
                    xfer(4'h0, s_io, s_en);
                    got = {got[3:0], s_io};
                    if (s_en !== en_exp) en_ok = 1'b0;
                end
            end else begin
                for (int b = 0; b < 8; b++) begin
                    xfer(4'h0, s_io, s_en);
                    got = {got[6:0], s_io[1]};
                    if (s_en !== en_exp) en_ok = 1'b0;
                end
            end
            total++;
            if (got !== ref_mem[(addr + k) % DEPTH]) begin
                bad++;
                $display("FAIL %s data[%0d]: got %h need %h", nm, k, got, ref_mem[(addr + k) % DEPTH]);
            end
            total++;
            if (!en_ok) begin
                bad++;
                $display("FAIL %s data_io_en[%0d]: got wrong enable, need %h", nm, k, en_exp);
            end
        end
        end_frame();
    endtask

    task automatic test_reset();
        total++; if (lnk.psram_io_o !== 4'h0)    begin bad++; $display("FAIL reset io_o: got %h need 0", lnk.psram_io_o); end
        total++; if (lnk.psram_io_en_o !== 4'h0) begin bad++; $display("FAIL reset io_en: got %h need 0", lnk.psram_io_en_o); end
        total++; if (busy !== 1'b0)              begin bad++; $display("FAIL reset busy: got %b need 0", busy); end
        total++; if (err !== 1'b0)               begin bad++; $display("FAIL reset err: got %b need 0", err); end
    endtask

    task automatic test_spi_rw();
        int e0;
        e0 = err_cycles;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        run_write(8'h02, 32'h10, 2);
        run_read(8'h03, 32'h10, 2, "spi_read");
        for (int k = 0; k < 3; k++) wbuf[k] = 8'($urandom);
        run_write(8'h02, 32'h155, 3);
        run_read(8'h0B, 32'h155, 3, "fast_read");
        total++;
        if (err_cycles != e0) begin bad++; $display("FAIL spi_err: got %0d pulses need 0", err_cycles - e0); end
    endtask

    task automatic test_quad_rw();
        wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'h56; wbuf[3] = 8'h78;
        run_write(8'h38, 32'h100, 4);
        run_read(8'hEB, 32'h100, 4, "quad_read");
    endtask

    task automatic test_wrap();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        run_write(8'h02, 32'h3FF, 2);
        run_read(8'h03, 32'h3FF, 2, "wrap_read");
        run_read(8'h03, 32'h000, 1, "wrap_byte0");
    endtask

    task automatic test_bad_opcode();
        logic [3:0] s_io, s_en;
        bit en_ok;
        int e0;
        e0 = err_cycles;
        begin_frame();
        send(32'h9F, 8, m_qpi);
        en_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            xfer(4'hF, s_io, s_en);
            if (s_en !== 4'h0) en_ok = 1'b0;
        end
        total++; if (err_cycles - e0 != 1) begin bad++; $display("FAIL bad_op_err: got %0d cycles need 1", err_cycles - e0); end
        total++; if (!en_ok)               begin bad++; $display("FAIL bad_op_io_en: got nonzero need 0"); end
        total++; if (busy !== 1'b1)        begin bad++; $display("FAIL bad_op_busy: got %b need 1", busy); end
        end_frame();
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL bad_op_idle: got %b need 0", busy); end
        run_read(8'h03, 32'h10, 2, "after_bad_op");
    endtask

    task automatic test_partial_write();
        wbuf[0] = 8'($urandom);
        run_write(8'h02, 32'h20, 1);
        begin_frame();
        send(32'h02, 8, 1'b0);
        send(32'h20, 24, 1'b0);
        send(32'(~wbuf[0] >> 4), 4, 1'b0);
        lnk.psram_ce_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0)              begin bad++; $display("FAIL partial_busy: got %b need 0", busy); end
        total++; if (lnk.psram_io_en_o !== 4'h0) begin bad++; $display("FAIL partial_io_en: got %h need 0", lnk.psram_io_en_o); end
        #40;
        run_read(8'h03, 32'h20, 1, "partial_keep");
    endtask

    task automatic test_random();
        int addr, n;
        logic [7:0] wop, rop;
        for (int it = 0; it < 6; it++) begin
            addr = int'($urandom_range(0, DEPTH - 1)) | (int'($urandom_range(0, 255)) << 16);
            n    = int'($urandom_range(1, 4));
            wop  = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h38;
            case ($urandom_range(0, 2))
                0:       rop = 8'h03;
                1:       rop = 8'h0B;
                default: rop = 8'hEB;
            endcase
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
            run_write(wop, addr, n);
            run_read(rop, addr, n, "random");
        end
    endtask

`ifdef PSRAM_RESP_QPI_EN
    task automatic test_qpi();
        run_cmd(8'h35);
        m_qpi = 1'b1;
        wbuf[0] = 8'hBE; wbuf[1] = 8'hEF;
        run_write(8'h02, 32'h40, 2);
        run_read(8'h03, 32'h40, 2, "qpi_read");
        run_cmd(8'h66);
        run_cmd(8'h99);
        m_qpi = 1'b0;
        run_read(8'h03, 32'h40, 2, "after_reset_pair");
    endtask
`endif

    task automatic test_reset_mid_read();
        logic [3:0] s_io, s_en;
        begin_frame();
        send(32'h03, 8, 1'b0);
        send(32'h10, 24, 1'b0);
        for (int i = 0; i < 3; i++) xfer(4'h0, s_io, s_en);
        #3 rst_n = 1'b0;
        #1;
        total++; if (lnk.psram_io_o !== 4'h0)    begin bad++; $display("FAIL mid_rst io_o: got %h need 0", lnk.psram_io_o); end
        total++; if (lnk.psram_io_en_o !== 4'h0) begin bad++; $display("FAIL mid_rst io_en: got %h need 0", lnk.psram_io_en_o); end
        total++; if (busy !== 1'b0)              begin bad++; $display("FAIL mid_rst busy: got %b need 0", busy); end
        @(negedge clk);
        lnk.psram_ce_i  = 1'b1;
        lnk.psram_sck_i = 1'b0;
        lnk.psram_io_i  = 4'h0;
        m_qpi = 1'b0;
        #20 rst_n = 1'b1;
        #40;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst idle: got %b need 0", busy); end
        run_read(8'h03, 32'h10, 2, "post_rst_mem");
    endtask

    initial begin
        rst_n           = 1'b0;
        lnk.psram_ce_i  = 1'b1;
        lnk.psram_sck_i = 1'b0;
        lnk.psram_io_i  = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #40;
        test_reset();
        test_spi_rw();
        test_quad_rw();
        test_wrap();
        test_bad_opcode();
        test_partial_write();
        test_random();
`ifdef PSRAM_RESP_QPI_EN
        test_qpi();
`endif
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
